// File: rtl/fu_wb_arbiter.sv
// Collects one-cycle FU completion pulses into per-FU holding slots and drives the single register-file write port.
// Latency: finish in cycle t -> fu_busy in t+1 -> registered writeback in t+2 when uncontended; one writeback per cycle sustained.
// Backpressure: wb_stall suppresses the grant and holds every slot; a finish at a full, ungranted slot is dropped and flags overflow.
module fu_wb_arbiter #(
    parameter int N_FU = 5,
    parameter int DW   = 32,
    parameter int RW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_FU-1:0]   fu_finish,
    input  logic [N_FU*DW-1:0] fu_res,
    input  logic [N_FU*RW-1:0] fu_rd,
    input  logic              wb_stall,
    output logic              wb_valid,
    output logic [RW-1:0]     wb_rd,
    output logic [DW-1:0]     wb_data,
    output logic [2:0]        wb_fu,
    output logic [N_FU-1:0]   fu_busy,
    output logic              overflow
);

    // Width of an FU index / round-robin pointer.
    localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_FU - 1);
    localparam logic [PW:0]   N_FU_EXT = (PW+1)'(N_FU);

    // Holding slots, one per FU.
    logic [N_FU-1:0] slot_vld;
    logic [DW-1:0]   slot_dat [N_FU];
    logic [RW-1:0]   slot_rd  [N_FU];

    // Round-robin pointer: the first slot considered in the next search.
    logic [PW-1:0]   ptr;

    // Grant decision for the current cycle.
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [N_FU-1:0] gnt_oh;
    logic [PW:0]     cand;

    // Per-FU finish classification.
    logic [N_FU-1:0] fin_ok;
    logic [N_FU-1:0] cap_en;
    logic [N_FU-1:0] ovf_hit;

    // Round-robin search: walk offsets from the far end down so the slot
    // closest to ptr (wrapping upward) is the one left standing.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = '0;
        for (int k = N_FU - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= N_FU_EXT) begin
                cand = cand - N_FU_EXT;
            end
            if (!wb_stall && slot_vld[cand[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Classify each finish: x0 targets are discarded outright; a slot being
    // granted at this edge is free to take a new result, otherwise a full
    // slot rejects it and raises overflow.
    always_comb begin
        fin_ok  = '0;
        cap_en  = '0;
        ovf_hit = '0;
        for (int i = 0; i < N_FU; i++) begin
            fin_ok[i]  = fu_finish[i] && (fu_rd[i*RW +: RW] != '0);
            cap_en[i]  = fin_ok[i] && (!slot_vld[i] || gnt_oh[i]);
            ovf_hit[i] = fin_ok[i] && slot_vld[i] && !gnt_oh[i];
        end
    end

    // Slot state: capture wins over the grant-clear so a back-to-back
    // result on the grant edge is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            for (int i = 0; i < N_FU; i++) begin
                slot_dat[i] <= '0;
                slot_rd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (cap_en[i]) begin
                    slot_vld[i] <= 1'b1;
                    slot_dat[i] <= fu_res[i*DW +: DW];
                    slot_rd[i]  <= fu_rd[i*RW +: RW];
                end else if (gnt_oh[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Writeback registers and pointer: address/data/index hold when idle,
    // pointer moves just past the granted slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_fu    <= '0;
            ptr      <= '0;
        end else if (gnt_vld) begin
            wb_valid <= 1'b1;
            wb_rd    <= slot_rd[gnt_idx];
            wb_data  <= slot_dat[gnt_idx];
            wb_fu    <= 3'(gnt_idx);
            ptr      <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    // Sticky overflow: only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (|ovf_hit) begin
            overflow <= 1'b1;
        end
    end

    assign fu_busy = slot_vld;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
module tb_fu_wb_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int RW = 5;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      fu_finish;
    logic [N*DW-1:0]   fu_res;
    logic [N*RW-1:0]   fu_rd;
    logic              wb_stall;
    logic              wb_valid;
    logic [RW-1:0]     wb_rd;
    logic [DW-1:0]     wb_data;
    logic [2:0]        wb_fu;
    logic [N-1:0]      fu_busy;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 0;

    fu_wb_arbiter #(.N_FU(N), .DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fu_finish (fu_finish),
        .fu_res    (fu_res),
        .fu_rd     (fu_rd),
        .wb_stall  (wb_stall),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_fu     (wb_fu),
        .fu_busy   (fu_busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending results per FU, a next-turn index, and the
    // expected writeback outputs.
    bit          m_v  [N];
    logic [31:0] m_d  [N];
    logic [4:0]  m_r  [N];
    int          m_ptr;
    int          m_g;
    bit          e_wbv;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [2:0]  e_fu;
    bit          e_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_d[i] = '0; m_r[i] = '0;
            end
            m_ptr = 0; e_wbv = 0; e_rd = '0; e_data = '0; e_fu = '0; e_ovf = 0;
        end else begin
            m_g = -1;
            if (!wb_stall) begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && m_v[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                end
            end
            if (m_g >= 0) begin
                e_wbv  = 1;
                e_rd   = m_r[m_g];
                e_data = m_d[m_g];
                e_fu   = 3'(m_g);
                m_v[m_g] = 0;
                m_ptr  = (m_g + 1) % N;
            end else begin
                e_wbv = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (fu_finish[i] && fu_rd[i*RW +: RW] != 0) begin
                    if (!m_v[i]) begin
                        m_v[i] = 1;
                        m_r[i] = fu_rd[i*RW +: RW];
                        m_d[i] = fu_res[i*DW +: DW];
                    end else begin
                        e_ovf = 1;
                    end
                end
            end
        end
    end

    // Compare every cycle, midway between rising edges.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            logic [N-1:0] busy_exp;
            for (int i = 0; i < N; i++) busy_exp[i] = m_v[i];
            chk("wb_valid", 64'(wb_valid), 64'(e_wbv));
            chk("wb_rd",    64'(wb_rd),    64'(e_rd));
            chk("wb_data",  64'(wb_data),  64'(e_data));
            chk("wb_fu",    64'(wb_fu),    64'(e_fu));
            chk("fu_busy",  64'(fu_busy),  64'(busy_exp));
            chk("overflow", 64'(overflow), 64'(e_ovf));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        fu_finish = '0;
        fu_rd     = '0;
        fu_res    = '0;
    endtask

    task automatic drive_fin(input int i, input logic [4:0] rd, input logic [31:0] d);
        fu_finish[i]        = 1'b1;
        fu_rd[i*RW +: RW]   = rd;
        fu_res[i*DW +: DW]  = d;
    endtask

    // One lone finish, drained fully; leaves the pointer at i+1.
    task automatic single(input int i);
        tick(); drive_fin(i, 5'd1, 32'h5A5A_0000 + 32'(i));
        tick(); clr();
        tick(); tick();
    endtask

    // All FUs finish together; writebacks must follow round-robin from first.
    task automatic burst_order(input int first);
        tick();
        for (int i = 0; i < N; i++) drive_fin(i, 5'(i + 1), $urandom);
        tick(); clr();
        chk("burst_busy", 64'(fu_busy), 64'h1F);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("burst_vld", 64'(wb_valid), 64'd1);
            chk("burst_fu",  64'(wb_fu),    64'((first + k) % N));
            chk("burst_rd",  64'(wb_rd),    64'((first + k) % N + 1));
        end
        tick();
        chk("burst_end", 64'(wb_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_stall = 1'b0;
        clr();
        #1;
        chk("rst_vld",  64'(wb_valid), 64'd0);
        chk("rst_busy", 64'(fu_busy),  64'd0);
        chk("rst_ovf",  64'(overflow), 64'd0);
        chk("rst_rd",   64'(wb_rd),    64'd0);
        chk("rst_data", 64'(wb_data),  64'd0);
        chk("rst_fu",   64'(wb_fu),    64'd0);
        tick(); tick();
        rst_n = 1'b1;
        check_en = 1;

        // Single uncontended finish.
        tick(); drive_fin(2, 5'd7, 32'hDEADBEEF);
        tick(); clr();
        chk("t1_busy", 64'(fu_busy), 64'b00100);
        chk("t1_vld0", 64'(wb_valid), 64'd0);
        tick();
        chk("t1_vld",  64'(wb_valid), 64'd1);
        chk("t1_rd",   64'(wb_rd),    64'd7);
        chk("t1_data", 64'(wb_data),  64'hDEADBEEF);
        chk("t1_fu",   64'(wb_fu),    64'd2);
        chk("t1_busy0", 64'(fu_busy), 64'd0);
        tick();
        chk("t1_vld1", 64'(wb_valid), 64'd0);

        // Bursts: pointer back to 0, then advanced to 3.
        single(4);
        burst_order(0);
        burst_order(0);
        single(2);
        burst_order(3);

        // Stall with FU1 and FU3 pending.
        single(4);
        tick(); wb_stall = 1'b1; drive_fin(1, 5'd11, 32'h111); drive_fin(3, 5'd13, 32'h333);
        tick(); clr();
        for (int c = 0; c < 4; c++) begin
            chk("st_busy", 64'(fu_busy), 64'b01010);
            chk("st_vld",  64'(wb_valid), 64'd0);
            if (c < 3) tick();
        end
        wb_stall = 1'b0;
        tick();
        chk("st_fu1", 64'(wb_fu), 64'd1);
        chk("st_v1",  64'(wb_valid), 64'd1);
        tick();
        chk("st_fu3", 64'(wb_fu), 64'd3);
        chk("st_v3",  64'(wb_valid), 64'd1);
        chk("st_ovf", 64'(overflow), 64'd0);

        // Finish to x0 is discarded.
        tick(); drive_fin(0, 5'd0, 32'hFFFF);
        tick(); clr();
        chk("x0_busy", 64'(fu_busy), 64'd0);
        tick();
        chk("x0_vld",  64'(wb_valid), 64'd0);
        chk("x0_ovf",  64'(overflow), 64'd0);

        // Re-finish on the grant edge.
        tick(); drive_fin(1, 5'd9, 32'h11);
        tick(); clr(); drive_fin(1, 5'd10, 32'h22);
        tick(); clr();
        chk("rf_rd1", 64'(wb_rd),   64'd9);
        chk("rf_d1",  64'(wb_data), 64'h11);
        tick();
        chk("rf_v2",  64'(wb_valid), 64'd1);
        chk("rf_rd2", 64'(wb_rd),   64'd10);
        chk("rf_d2",  64'(wb_data), 64'h22);
        chk("rf_ovf", 64'(overflow), 64'd0);

        // Asynchronous reset in the middle of a drain.
        tick();
        for (int i = 0; i < N; i++) drive_fin(i, 5'(i + 1), $urandom);
        tick(); clr();
        tick();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld",  64'(wb_valid), 64'd0);
        chk("ar_busy", 64'(fu_busy),  64'd0);
        chk("ar_rd",   64'(wb_rd),    64'd0);
        chk("ar_data", 64'(wb_data),  64'd0);
        chk("ar_fu",   64'(wb_fu),    64'd0);
        tick();
        rst_n = 1'b1;

        // Double finish while stalled: first result kept, overflow sticky.
        tick(); wb_stall = 1'b1; drive_fin(4, 5'd20, 32'hAAAA_0001);
        tick(); clr(); drive_fin(4, 5'd21, 32'hBBBB_0002);
        tick(); clr();
        chk("ov_flag", 64'(overflow), 64'd1);
        chk("ov_busy", 64'(fu_busy),  64'b10000);
        wb_stall = 1'b0;
        tick();
        chk("ov_vld",  64'(wb_valid), 64'd1);
        chk("ov_rd",   64'(wb_rd),    64'd20);
        chk("ov_data", 64'(wb_data),  64'hAAAA_0001);
        tick(); tick();
        chk("ov_stky", 64'(overflow), 64'd1);
        chk("ov_idle", 64'(wb_valid), 64'd0);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            clr();
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            wb_stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    drive_fin(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
                end
            end
        end
        tick(); clr(); wb_stall = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
